led_cal_sequencer: RTL

Parametrised successor to the single-ID calibration FSM. It runs a fully automatic binary structured-light calibration of the LED strand. For each bit of the LED ID it drives a lit/unlit pattern on the strand and waits for a captured camera frame. It then scans the frame buffer, thresholds each pixel and accumulates that bit into an internal per-pixel calibration table, which HDMI reads back. A manual single-LED "ID shower" mode is kept for alignment when calibration is off.

---
 rtl/led_cal_sequencer_if.sv | 39 +++
 rtl/led_cal_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/led_cal_sequencer_if.sv
// Strand, camera-handshake, frame-buffer and calibration-table signals of led_cal_sequencer.
// slave is the sequencer side; master is the surrounding system (strand driver, camera, HDMI).
interface led_cal_sequencer_if #(
  parameter int LED_ADDRESS_WIDTH       = 6,
  parameter int NUM_FRAME_BUFFER_PIXELS = 64800
);
  localparam int ID_BITS = LED_ADDRESS_WIDTH + 1;
  localparam int PIX_W   = $clog2(NUM_FRAME_BUFFER_PIXELS);

  logic               calibration_on;
  logic               increment_id;
  logic               capture_shown_frame;
  logic [ID_BITS-1:0] next_led_request;
  logic [7:0]         green_out;
  logic [7:0]         red_out;
  logic [7:0]         blue_out;
  logic               color_valid;
  logic               displayed_frame_valid;
  logic               cal_busy;
  logic               cal_done;
  logic [PIX_W-1:0]   cal_table_read_request_address;
  logic [ID_BITS-1:0] cal_table_read_data;
  logic [PIX_W-1:0]   frame_buffer_read_request_address;
  logic [15:0]        frame_buffer_data;

  modport slave (
    input  calibration_on, increment_id, capture_shown_frame, next_led_request,
           cal_table_read_request_address, frame_buffer_data,
    output green_out, red_out, blue_out, color_valid, displayed_frame_valid,
           cal_busy, cal_done, cal_table_read_data, frame_buffer_read_request_address
  );

  modport master (
    output calibration_on, increment_id, capture_shown_frame, next_led_request,
           cal_table_read_request_address, frame_buffer_data,
    input  green_out, red_out, blue_out, color_valid, displayed_frame_valid,
           cal_busy, cal_done, cal_table_read_data, frame_buffer_read_request_address
  );
endinterface

// File: rtl/led_cal_sequencer.sv
// Binary structured-light LED calibration: show one ID bit per frame, scan the frame, build a pixel->ID table.
// Define CAL_GRAY_CODE_EN for Gray-coded patterns with a Gray->binary decode on the table read port.
module led_cal_sequencer #(
  parameter int          NUM_LEDS                = 50,
  parameter int          LED_ADDRESS_WIDTH       = 6,
  parameter int          NUM_FRAME_BUFFER_PIXELS = 64800,
  parameter int          FB_READ_LATENCY         = 2,
  parameter logic [7:0]  THRESHOLD               = 8'd96,
  parameter logic [23:0] LIT_COLOR               = 24'hFFFFFF
) (
  input logic                clk,
  input logic                rst,
  led_cal_sequencer_if.slave bus
);
  localparam int ID_BITS = LED_ADDRESS_WIDTH + 1;
  localparam int PIX_W   = $clog2(NUM_FRAME_BUFFER_PIXELS);
  localparam int BIT_W   = $clog2(ID_BITS);
  localparam int LAT     = FB_READ_LATENCY;
  localparam int CNT_W   = $clog2(NUM_FRAME_BUFFER_PIXELS + LAT + 1) + 1;

  localparam logic [ID_BITS-1:0] LAST_LED  = ID_BITS'(NUM_LEDS - 1);
  localparam logic [PIX_W-1:0]   LAST_PIX  = PIX_W'(NUM_FRAME_BUFFER_PIXELS - 1);
  localparam logic [CNT_W-1:0]   SCAN_END  = CNT_W'(NUM_FRAME_BUFFER_PIXELS + LAT);
  localparam logic [CNT_W-1:0]   NUM_PIX_C = CNT_W'(NUM_FRAME_BUFFER_PIXELS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SHOW = 3'd1;
  localparam logic [2:0] S_SCAN = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  function automatic logic [ID_BITS-1:0] led_code(input logic [ID_BITS-1:0] id);
`ifdef CAL_GRAY_CODE_EN
    return id ^ (id >> 1);
`else
    return id;
`endif
  endfunction

  logic [2:0]         state_q, state_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [ID_BITS-1:0] manual_id_q, manual_id_d;
  logic               cal_on_prev_q;
  logic [ID_BITS-1:0] req_prev_q;
  logic [1:0]         wrap_cnt_q, wrap_cnt_d;
  logic               dfv_q, dfv_d;
  logic [23:0]        color_q, color_d;
  logic               color_valid_q;
  logic [CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [PIX_W-1:0]   fb_addr_q, fb_addr_d;
  logic [LAT:1]       vld_q, vld_d;
  logic [PIX_W-1:0]   addr_q [1:LAT];
  logic [ID_BITS-1:0] tbl_out_q, tbl_out_d;

  logic               busy, cal_rise, wrap, led_lit, lit_px, wr_en;
  logic [LAT:0]       stage_vld;
  logic [PIX_W-1:0]   stage_addr [0:LAT];
  logic [ID_BITS-1:0] pattern_code, rd_a_q, rd_b_q, wr_data;
  logic [7:0]         brightness;

  assign busy     = (state_q == S_SHOW) || (state_q == S_SCAN) || (state_q == S_NEXT);
  assign cal_rise = bus.calibration_on && !cal_on_prev_q;
  assign wrap     = (req_prev_q == LAST_LED) && (bus.next_led_request == '0);

  // NOTE: every _d signal is given its hold value before any branch, so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    manual_id_d = manual_id_q;
    wrap_cnt_d  = wrap_cnt_q;
    dfv_d       = dfv_q;
    scan_cnt_d  = scan_cnt_q;
    fb_addr_d   = fb_addr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.increment_id)
          manual_id_d = (manual_id_q == LAST_LED) ? '0 : manual_id_q + ID_BITS'(1);
        if (cal_rise) begin
          state_d    = S_SHOW;
          bit_d      = '0;
          wrap_cnt_d = '0;
          dfv_d      = 1'b0;
        end
      end
      S_SHOW: begin
        if (wrap && wrap_cnt_q != 2'd2) wrap_cnt_d = wrap_cnt_q + 2'd1;
        if (wrap && wrap_cnt_q == 2'd1) dfv_d = 1'b1;
        if (dfv_q && bus.capture_shown_frame) begin
          state_d    = S_SCAN;
          scan_cnt_d = '0;
          fb_addr_d  = '0;
          dfv_d      = 1'b0;
        end
      end
      S_SCAN: begin
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        if (fb_addr_q != LAST_PIX) fb_addr_d = fb_addr_q + PIX_W'(1);
        if (scan_cnt_q == SCAN_END) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (bit_q == BIT_W'(ID_BITS - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_SHOW;
          bit_d      = bit_q + BIT_W'(1);
          wrap_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (busy && !bus.calibration_on) begin
      state_d = S_IDLE;
      dfv_d   = 1'b0;
    end
  end

  // Strand colour: the bit pattern while calibrating, the single manual LED otherwise.
  always_comb begin
    pattern_code = led_code(bus.next_led_request + ID_BITS'(1)) >> bit_q;
    led_lit      = 1'b0;
    if (bus.next_led_request <= LAST_LED)
      led_lit = busy ? pattern_code[0] : (bus.next_led_request == manual_id_q);
    color_d = led_lit ? LIT_COLOR : 24'h000000;
  end

  // Scan pipeline: stage 0 is the issued address, stage LAT carries the returned pixel.
  always_comb begin
    stage_vld[0]  = (state_q == S_SCAN) && (scan_cnt_q < NUM_PIX_C);
    stage_addr[0] = fb_addr_q;
    for (int k = 1; k <= LAT; k++) begin
      stage_vld[k]  = vld_q[k];
      stage_addr[k] = addr_q[k];
      vld_d[k]      = stage_vld[k-1];
    end
    brightness = {2'b00, bus.frame_buffer_data[15:11], 1'b0}
               + {2'b00, bus.frame_buffer_data[10:5]}
               + {2'b00, bus.frame_buffer_data[4:0], 1'b0};
    lit_px  = brightness > THRESHOLD;
    wr_en   = stage_vld[LAT] && (state_q == S_SCAN) && !rst;
    wr_data = (bit_q == '0) ? ID_BITS'(lit_px) : (rd_a_q | (ID_BITS'(lit_px) << bit_q));
  end

  always_comb begin
`ifdef CAL_GRAY_CODE_EN
    tbl_out_d[ID_BITS-1] = rd_b_q[ID_BITS-1];
    for (int i = ID_BITS - 2; i >= 0; i--) tbl_out_d[i] = tbl_out_d[i+1] ^ rd_b_q[i];
`else
    tbl_out_d = rd_b_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      bit_q         <= '0;
      manual_id_q   <= '0;
      cal_on_prev_q <= 1'b0;
      req_prev_q    <= '0;
      wrap_cnt_q    <= '0;
      dfv_q         <= 1'b0;
      color_q       <= '0;
      color_valid_q <= 1'b0;
      scan_cnt_q    <= '0;
      fb_addr_q     <= '0;
      vld_q         <= '0;
      tbl_out_q     <= '0;
    end else begin
      state_q       <= state_d;
      bit_q         <= bit_d;
      manual_id_q   <= manual_id_d;
      cal_on_prev_q <= bus.calibration_on;
      req_prev_q    <= bus.next_led_request;
      wrap_cnt_q    <= wrap_cnt_d;
      dfv_q         <= dfv_d;
      color_q       <= color_d;
      color_valid_q <= 1'b1;
      scan_cnt_q    <= scan_cnt_d;
      fb_addr_q     <= fb_addr_d;
      vld_q         <= vld_d;
      tbl_out_q     <= tbl_out_d;
    end
  end

  // NOTE: the table RAM and the pipeline address/read registers are deliberately not reset;
  // validity is carried by the reset vld_q bits, and RAM contents survive rst.
  logic [ID_BITS-1:0] cal_mem [NUM_FRAME_BUFFER_PIXELS];

  always_ff @(posedge clk) begin
    for (int k = 1; k <= LAT; k++) addr_q[k] <= stage_addr[k-1];
    if (wr_en) cal_mem[stage_addr[LAT]] <= wr_data;
    rd_a_q <= cal_mem[stage_addr[LAT-1]];
    rd_b_q <= cal_mem[bus.cal_table_read_request_address];
  end

  assign bus.green_out                         = color_q[23:16];
  assign bus.red_out                           = color_q[15:8];
  assign bus.blue_out                          = color_q[7:0];
  assign bus.color_valid                       = color_valid_q;
  assign bus.displayed_frame_valid             = dfv_q;
  assign bus.cal_busy                          = busy;
  assign bus.cal_done                          = (state_q == S_DONE);
  assign bus.cal_table_read_data               = tbl_out_q;
  assign bus.frame_buffer_read_request_address = fb_addr_q;
endmodule
